// File: rtl/writeback_scheduler_pkg.sv
// Shared widths and writeback records for the register-bank write port
// and the long-latency result path.
package writeback_scheduler_pkg;

  localparam int unsigned bREG  = 32;
  localparam int unsigned nREG  = 32;
  localparam int unsigned bSEL  = 5;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned bCNT  = 3;
  localparam int unsigned bPTR  = $clog2(DEPTH);

  localparam logic [bSEL-1:0] REG_ZERO = '0;

  // Writeback request as produced by the WB stage or a mul/div unit
  typedef struct packed {
    logic            valid;
    logic [bSEL-1:0] sel;
    logic [bREG-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic [bSEL-1:0] sel;
    logic [bREG-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/writeback_scheduler_if.sv
// Bundle of WB, long-op result, decode hazard and register-bank write signals.
interface writeback_scheduler_if;
  import writeback_scheduler_pkg::*;

  logic            wbValid;
  logic [bSEL-1:0] wbReg;
  logic [bREG-1:0] wbData;
  logic            wbStall;
  logic            enqValid;
  logic [bSEL-1:0] enqReg;
  logic [bREG-1:0] enqData;
  logic            enqReady;
  logic            issueValid;
  logic [bSEL-1:0] issueReg;
  logic [bSEL-1:0] chkReg1;
  logic [bSEL-1:0] chkReg2;
  logic [bSEL-1:0] chkRegD;
  logic            hazard;
  logic            enWriteReg;
  logic [bSEL-1:0] selWriteReg;
  logic [bREG-1:0] WriteData;

  modport master (
    output wbValid, wbReg, wbData, enqValid, enqReg, enqData,
           issueValid, issueReg, chkReg1, chkReg2, chkRegD,
    input  wbStall, enqReady, hazard, enWriteReg, selWriteReg, WriteData
  );

  modport slave (
    input  wbValid, wbReg, wbData, enqValid, enqReg, enqData,
           issueValid, issueReg, chkReg1, chkReg2, chkRegD,
    output wbStall, enqReady, hazard, enWriteReg, selWriteReg, WriteData
  );

endinterface

// File: rtl/writeback_scheduler_wb_result_fifo.sv
// Small in-order result FIFO holding {dest, data} from long-latency units.
module wb_result_fifo
  import writeback_scheduler_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  fifo_entry_t push_data_i,
  input  logic        pop_i,
  output fifo_entry_t head_o,
  output logic        full_c_o,
  output logic        empty_c_o
);

  fifo_entry_t     mem_q [DEPTH];
  logic [bPTR-1:0] wr_ptr_q, wr_ptr_d;
  logic [bPTR-1:0] rd_ptr_q, rd_ptr_d;
  logic [bCNT-1:0] count_q, count_d;
  logic            push_ok, pop_ok;

  assign full_c_o  = (count_q == bCNT'(DEPTH));
  assign empty_c_o = (count_q == '0);
  assign push_ok   = push_i && !full_c_o;
  assign pop_ok    = pop_i && !empty_c_o;
  assign head_o    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + bPTR'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + bPTR'(1);
    if (push_ok && !pop_ok)      count_d = count_q + bCNT'(1);
    else if (!push_ok && pop_ok) count_d = count_q - bCNT'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted valid
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/writeback_scheduler.sv
// Single register-bank write port arbiter: merges WB-stage results with queued
// long-latency results and tracks pending long-op destinations for decode.
module writeback_scheduler
  import writeback_scheduler_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  writeback_scheduler_if.slave  bus
);

  fifo_entry_t     head;
  fifo_entry_t     push_data;
  logic            full_c, empty_c;
  logic            push_c, pop_c;
  wb_req_t         wr_q, wr_d;
  logic [nREG-1:0] pending_q, pending_d;

  assign push_c         = bus.enqValid && !full_c;
  assign push_data.sel  = bus.enqReg;
  assign push_data.data = bus.enqData;

  wb_result_fifo u_fifo (
    .clk         (clock),
    .rst_n       (reset),
    .push_i      (push_c),
    .push_data_i (push_data),
    .pop_i       (pop_c),
    .head_o      (head),
    .full_c_o    (full_c),
    .empty_c_o   (empty_c)
  );

  // Arbitration: a full FIFO beats WB, WB beats a non-full FIFO
  always_comb begin
    pop_c      = 1'b0;
    wr_d       = wr_q;
    wr_d.valid = 1'b0;
    if (full_c || (!bus.wbValid && !empty_c)) begin
      pop_c      = 1'b1;
      wr_d.valid = (head.sel != REG_ZERO);
      wr_d.sel   = head.sel;
      wr_d.data  = head.data;
    end else if (bus.wbValid) begin
      wr_d.valid = (bus.wbReg != REG_ZERO);
      wr_d.sel   = bus.wbReg;
      wr_d.data  = bus.wbData;
    end
  end

  // Scoreboard: the issue set is applied after the pop clear so it wins
  always_comb begin
    pending_d = pending_q;
    if (pop_c) pending_d[head.sel] = 1'b0;
    if (bus.issueValid && (bus.issueReg != REG_ZERO)) pending_d[bus.issueReg] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q      <= '0;
      pending_q <= '0;
    end else begin
      wr_q      <= wr_d;
      pending_q <= pending_d;
    end
  end

  assign bus.wbStall     = full_c;
  assign bus.enqReady    = !full_c;
  assign bus.hazard      = pending_q[bus.chkReg1] | pending_q[bus.chkReg2] | pending_q[bus.chkRegD];
  assign bus.enWriteReg  = wr_q.valid;
  assign bus.selWriteReg = wr_q.sel;
  assign bus.WriteData   = wr_q.data;

endmodule

// File: tb/tb_writeback_scheduler.sv
// Testbench for writeback_scheduler: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_writeback_scheduler;
  import writeback_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  writeback_scheduler_if bus ();

  writeback_scheduler dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  bit          mpend[32];
  logic        m_en;
  logic [4:0]  m_sel;
  logic [31:0] m_data;

  function automatic bit m_full();
    return mq.size() == 4;
  endfunction

  function automatic bit m_hazard(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    return mpend[a] | mpend[b] | mpend[d];
  endfunction

  task automatic idle();
    bus.wbValid    = 1'b0;
    bus.wbReg      = '0;
    bus.wbData     = '0;
    bus.enqValid   = 1'b0;
    bus.enqReg     = '0;
    bus.enqData    = '0;
    bus.issueValid = 1'b0;
    bus.issueReg   = '0;
    bus.chkReg1    = '0;
    bus.chkReg2    = '0;
    bus.chkRegD    = '0;
  endtask

  // Advance one clock, updating the model from the inputs present before the edge
  task automatic step();
    ent_t e;
    bit   was_full;
    if (!rst_n) begin
      mq.delete();
      foreach (mpend[i]) mpend[i] = 1'b0;
      m_en   = 1'b0;
      m_sel  = '0;
      m_data = '0;
    end else begin
      was_full = m_full();
      if (bus.issueValid && bus.issueReg != 5'd0 && mpend[bus.issueReg]) begin
        failures++;
        $display("FAIL illegal_issue reg=%0d already pending", bus.issueReg);
      end
      if (was_full || (!bus.wbValid && mq.size() > 0)) begin
        e      = mq.pop_front();
        m_en   = (e.sel != 5'd0);
        m_sel  = e.sel;
        m_data = e.data;
        mpend[e.sel] = 1'b0;
      end else if (bus.wbValid) begin
        m_en   = (bus.wbReg != 5'd0);
        m_sel  = bus.wbReg;
        m_data = bus.wbData;
      end else begin
        m_en = 1'b0;
      end
      if (bus.enqValid && !was_full) mq.push_back('{bus.enqReg, bus.enqData});
      if (bus.issueValid && bus.issueReg != 5'd0) mpend[bus.issueReg] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    bus.wbValid = 1'b1;
    bus.wbReg   = 5'd3;
    bus.wbData  = 32'h5555_AAAA;
    step();
    step();
    checks++; if (bus.enWriteReg !== 1'b0) begin failures++; $display("FAIL reset_en got=%0b exp=0", bus.enWriteReg); end
    checks++; if (bus.selWriteReg !== 5'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", bus.selWriteReg); end
    checks++; if (bus.WriteData !== 32'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.WriteData); end
    checks++; if (bus.enqReady !== 1'b1) begin failures++; $display("FAIL reset_enq_ready got=%0b exp=1", bus.enqReady); end
    checks++; if (bus.wbStall !== 1'b0) begin failures++; $display("FAIL reset_wb_stall got=%0b exp=0", bus.wbStall); end
    checks++; if (bus.hazard !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%0b exp=0", bus.hazard); end
    rst_n = 1'b1;
    idle();
  endtask

  task automatic test_wb_only();
    idle();
    bus.wbValid = 1'b1;
    bus.wbReg   = 5'd5;
    bus.wbData  = 32'hDEAD_BEEF;
    step();
    checks++; if (bus.enWriteReg !== 1'b1) begin failures++; $display("FAIL wb_en got=%0b exp=1", bus.enWriteReg); end
    checks++; if (bus.selWriteReg !== 5'd5) begin failures++; $display("FAIL wb_sel got=%0d exp=5", bus.selWriteReg); end
    checks++; if (bus.WriteData !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wb_data got=%h exp=deadbeef", bus.WriteData); end
    idle();
    step();
    checks++; if (bus.enWriteReg !== 1'b0) begin failures++; $display("FAIL wb_idle_en got=%0b exp=0", bus.enWriteReg); end
    checks++; if (bus.selWriteReg !== 5'd5) begin failures++; $display("FAIL wb_idle_sel_hold got=%0d exp=5", bus.selWriteReg); end
  endtask

  task automatic test_long_op();
    idle();
    bus.issueValid = 1'b1;
    bus.issueReg   = 5'd9;
    step();
    idle();
    bus.chkReg1 = 5'd9;
    #1;
    checks++; if (bus.hazard !== 1'b1) begin failures++; $display("FAIL long_hazard_set got=%0b exp=1", bus.hazard); end
    bus.enqValid = 1'b1;
    bus.enqReg   = 5'd9;
    bus.enqData  = 32'h0000_1234;
    step();
    bus.enqValid = 1'b0;
    #1;
    checks++; if (bus.hazard !== 1'b1) begin failures++; $display("FAIL long_hazard_queued got=%0b exp=1", bus.hazard); end
    checks++; if (bus.enWriteReg !== 1'b0) begin failures++; $display("FAIL long_not_yet got=%0b exp=0", bus.enWriteReg); end
    step();
    checks++; if (bus.enWriteReg !== 1'b1 || bus.selWriteReg !== 5'd9 || bus.WriteData !== 32'h1234)
      begin failures++; $display("FAIL long_write got=%0b/%0d/%h exp=1/9/1234", bus.enWriteReg, bus.selWriteReg, bus.WriteData); end
    checks++; if (bus.hazard !== 1'b0) begin failures++; $display("FAIL long_hazard_clear got=%0b exp=0", bus.hazard); end
    idle();
  endtask

  task automatic test_full_priority();
    for (int k = 1; k <= 4; k++) begin
      idle();
      bus.issueValid = 1'b1;
      bus.issueReg   = 5'(k);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      bus.wbValid  = 1'b1;
      bus.wbReg    = 5'(20 + k);
      bus.wbData   = 32'hA000 + 32'(k);
      bus.enqValid = 1'b1;
      bus.enqReg   = 5'(k + 1);
      bus.enqData  = 32'hB000 + 32'(k);
      #1;
      checks++; if (bus.enqReady !== 1'b1) begin failures++; $display("FAIL fill_ready k=%0d got=%0b exp=1", k, bus.enqReady); end
      step();
      checks++; if (bus.enWriteReg !== 1'b1 || bus.selWriteReg !== 5'(20 + k))
        begin failures++; $display("FAIL fill_wb k=%0d got=%0b/%0d exp=1/%0d", k, bus.enWriteReg, bus.selWriteReg, 20 + k); end
    end
    idle();
    bus.wbValid = 1'b1;
    bus.wbReg   = 5'd25;
    bus.wbData  = 32'hC025;
    #1;
    checks++; if (bus.wbStall !== 1'b1) begin failures++; $display("FAIL full_stall got=%0b exp=1", bus.wbStall); end
    checks++; if (bus.enqReady !== 1'b0) begin failures++; $display("FAIL full_ready got=%0b exp=0", bus.enqReady); end
    step();
    checks++; if (bus.selWriteReg !== 5'd1 || bus.WriteData !== 32'hB000)
      begin failures++; $display("FAIL full_pop_first got=%0d/%h exp=1/b000", bus.selWriteReg, bus.WriteData); end
    bus.issueValid = 1'b1;
    bus.issueReg   = 5'd5;
    #1;
    checks++; if (bus.wbStall !== 1'b0) begin failures++; $display("FAIL count3_stall got=%0b exp=0", bus.wbStall); end
    step();
    checks++; if (bus.selWriteReg !== 5'd25 || bus.WriteData !== 32'hC025)
      begin failures++; $display("FAIL wb_resume got=%0d/%h exp=25/c025", bus.selWriteReg, bus.WriteData); end
    idle();
    bus.enqValid = 1'b1;
    bus.enqReg   = 5'd5;
    bus.enqData  = 32'hB004;
    #1;
    checks++; if (bus.enqReady !== 1'b1) begin failures++; $display("FAIL pushpop_ready got=%0b exp=1", bus.enqReady); end
    step();
    checks++; if (bus.selWriteReg !== 5'd2) begin failures++; $display("FAIL pushpop_pop got=%0d exp=2", bus.selWriteReg); end
    idle();
    bus.wbValid = 1'b1;
    bus.wbReg   = 5'd26;
    bus.wbData  = 32'hC026;
    #1;
    checks++; if (bus.wbStall !== 1'b0) begin failures++; $display("FAIL pushpop_count3 got=%0b exp=0", bus.wbStall); end
    step();
    checks++; if (bus.selWriteReg !== 5'd26) begin failures++; $display("FAIL pushpop_wb got=%0d exp=26", bus.selWriteReg); end
    idle();
    for (int k = 3; k <= 5; k++) begin
      step();
      checks++; if (bus.enWriteReg !== 1'b1 || bus.selWriteReg !== 5'(k) || bus.WriteData !== 32'hB000 + 32'(k - 1))
        begin failures++; $display("FAIL drain k=%0d got=%0b/%0d/%h", k, bus.enWriteReg, bus.selWriteReg, bus.WriteData); end
    end
    step();
    checks++; if (bus.enWriteReg !== 1'b0) begin failures++; $display("FAIL drain_empty got=%0b exp=0", bus.enWriteReg); end
  endtask

  task automatic test_reg_zero();
    idle();
    bus.wbValid = 1'b1;
    bus.wbReg   = 5'd0;
    bus.wbData  = 32'h1111;
    step();
    checks++; if (bus.enWriteReg !== 1'b0) begin failures++; $display("FAIL r0_wb_en got=%0b exp=0", bus.enWriteReg); end
    idle();
    bus.issueValid = 1'b1;
    step();
    idle();
    #1;
    checks++; if (bus.hazard !== 1'b0) begin failures++; $display("FAIL r0_hazard got=%0b exp=0", bus.hazard); end
    bus.enqValid = 1'b1;
    bus.enqData  = 32'h2222;
    step();
    idle();
    step();
    checks++; if (bus.enWriteReg !== 1'b0) begin failures++; $display("FAIL r0_pop_en got=%0b exp=0", bus.enWriteReg); end
    bus.issueValid = 1'b1;
    bus.issueReg   = 5'd11;
    step();
    idle();
    bus.enqValid = 1'b1;
    bus.enqReg   = 5'd11;
    bus.enqData  = 32'h3333;
    step();
    idle();
    step();
    checks++; if (bus.enWriteReg !== 1'b1 || bus.selWriteReg !== 5'd11 || bus.WriteData !== 32'h3333)
      begin failures++; $display("FAIL r0_fifo_empty got=%0b/%0d/%h exp=1/11/3333", bus.enWriteReg, bus.selWriteReg, bus.WriteData); end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 12; k <= 14; k++) begin
      idle();
      bus.issueValid = 1'b1;
      bus.issueReg   = 5'(k);
      step();
    end
    for (int k = 12; k <= 14; k++) begin
      idle();
      bus.wbValid  = 1'b1;
      bus.wbReg    = 5'd30;
      bus.enqValid = 1'b1;
      bus.enqReg   = 5'(k);
      bus.enqData  = 32'(k);
      step();
    end
    idle();
    bus.chkReg1 = 5'd12;
    bus.chkReg2 = 5'd14;
    #1;
    checks++; if (bus.hazard !== 1'b1) begin failures++; $display("FAIL mid_hazard_before got=%0b exp=1", bus.hazard); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.hazard !== 1'b0) begin failures++; $display("FAIL mid_hazard_after got=%0b exp=0", bus.hazard); end
    checks++; if (bus.enqReady !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0b exp=1", bus.enqReady); end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.enWriteReg !== 1'b0) begin failures++; $display("FAIL mid_no_write k=%0d got=%0b exp=0", k, bus.enWriteReg); end
    end
  endtask

  task automatic test_random();
    logic [4:0] outq[$];
    logic [4:0] r;
    for (int c = 0; c < 400; c++) begin
      idle();
      bus.wbValid = 1'($urandom_range(0, 1));
      bus.wbReg   = 5'($urandom);
      bus.wbData  = $urandom;
      bus.chkReg1 = 5'($urandom);
      bus.chkReg2 = 5'($urandom);
      if (outq.size() > 0 && $urandom_range(0, 2) != 0) begin
        bus.enqValid = 1'b1;
        bus.enqReg   = outq[0];
        bus.enqData  = $urandom;
      end
      r = 5'($urandom_range(1, 31));
      bus.chkRegD = r;
      if ((outq.size() + mq.size()) < 4 && !m_hazard(bus.chkReg1, bus.chkReg2, r) && $urandom_range(0, 1) == 1) begin
        bus.issueValid = 1'b1;
        bus.issueReg   = r;
      end
      #1;
      checks++; if (bus.hazard !== m_hazard(bus.chkReg1, bus.chkReg2, bus.chkRegD))
        begin failures++; $display("FAIL rnd_hazard c=%0d got=%0b", c, bus.hazard); end
      checks++; if (bus.wbStall !== m_full() || bus.enqReady !== !m_full())
        begin failures++; $display("FAIL rnd_flow c=%0d stall=%0b ready=%0b exp_full=%0b", c, bus.wbStall, bus.enqReady, m_full()); end
      if (bus.enqValid && !m_full()) void'(outq.pop_front());
      if (bus.issueValid) outq.push_back(r);
      step();
      checks++; if (bus.enWriteReg !== m_en || bus.selWriteReg !== m_sel || bus.WriteData !== m_data)
        begin failures++; $display("FAIL rnd_write c=%0d got=%0b/%0d/%h exp=%0b/%0d/%h", c, bus.enWriteReg, bus.selWriteReg, bus.WriteData, m_en, m_sel, m_data); end
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_wb_only();
    test_long_op();
    test_full_priority();
    test_reg_zero();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
